// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command decoder.
package spi_cmd_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 6;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned OP_W           = 2;
  localparam int unsigned ERR_W          = 4;

  // High nibble of the STATUS response byte
  localparam logic [3:0] STATUS_MAGIC = 4'hA;

  // Opcode field carried in bits [7:6] of the first byte of a frame
  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_READ   = 2'b10,
    OP_STATUS = 2'b11
  } op_e;

  // Decoder FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ   = 3'd2,
    ST_STATUS = 3'd3,
    ST_DROP   = 3'd4
  } state_e;

endpackage

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: turns an SPI byte stream into register-file writes,
// streamed reads and a status byte.
// Optional feature macro: SPI_CMD_ERRCNT_EN -- when defined, a saturating
// 4-bit counter of illegal NOP opcodes is kept and reported in STATUS.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ack,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [BYTE_W-1:0] reg_wdata,
  output logic              reg_we,
  input  logic [BYTE_W-1:0] reg_rdata
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]   wdata_q, wdata_d;
  logic                tx_valid_q, tx_valid_d;
  logic                we;
  logic                err_inc;
  logic [ERR_W-1:0]    err_nib;
  op_e                 op;
  logic [ADDR_W-1:0]   op_addr;

  // Opcode byte field split
  assign op      = op_e'(rx_data[BYTE_W-1:BYTE_W-OP_W]);
  assign op_addr = rx_data[ADDR_W-1:0];

  // Next-state, address counter and write-strobe decode; cs_n high wins over everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    we      = 1'b0;
    err_inc = 1'b0;
    if (cs_n) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            case (op)
              OP_WRITE: begin
                state_d = ST_WRITE;
                cnt_d   = op_addr;
              end
              OP_READ: begin
                state_d = ST_READ;
                cnt_d   = op_addr;
              end
              OP_STATUS: begin
                state_d = ST_STATUS;
                cnt_d   = op_addr;
              end
              OP_NOP: begin
                if (op_addr != ADDR_W'(0)) begin
                  state_d = ST_DROP;
                  err_inc = 1'b1;
                end
              end
            endcase
          end
        end
        ST_WRITE: begin
          if (rx_valid) begin
            we      = 1'b1;
            wdata_d = rx_data;
            cnt_d   = cnt_q + ADDR_W'(1);
          end
        end
        ST_READ: begin
          if (tx_ack) begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        ST_STATUS: begin
          state_d = ST_STATUS;
        end
        ST_DROP: begin
          state_d = ST_DROP;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    tx_valid_d = (state_d == ST_READ) || (state_d == ST_STATUS);
  end

  // State, counter, held write data and tx_valid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wdata_q    <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      tx_valid_q <= tx_valid_d;
    end
  end

`ifdef SPI_CMD_ERRCNT_EN
  logic [ERR_W-1:0] err_q, err_d;

  // Saturating count of illegal NOP opcodes
  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  // Error counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_nib = err_q;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc;
  assign err_nib        = '0;
`endif

  // Register-file strobe and data act in the same cycle as the received byte
  assign reg_we    = we;
  assign reg_wdata = wdata_d;
  assign reg_addr  = cnt_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = (state_q == ST_READ) ? reg_rdata : {STATUS_MAGIC, err_nib};

endmodule
